// File: rtl/fifo_ram_dma_if.sv
// ============================================================================
//  Module   : fifo_ram_dma_if
//  Brief    : FIFO read port and RAM write port bundle for fifo_ram_dma.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_ram_dma_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int USDW_W = 8
);
    logic [DATA_W-1:0] fifo_q;
    logic [USDW_W-1:0] fifo_usdw;
    logic              fifo_rdreq;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d;
    logic              ram_wren;

    modport master (
        input  fifo_q, fifo_usdw,
        output fifo_rdreq, ram_addr, ram_d, ram_wren
    );

    modport slave (
        output fifo_q, fifo_usdw,
        input  fifo_rdreq, ram_addr, ram_d, ram_wren
    );
endinterface

`default_nettype wire

// File: rtl/fifo_ram_dma.sv
// ============================================================================
//  Module   : fifo_ram_dma
//  Brief    : Moves samples from a DC FIFO into on-chip RAM on a CPU start.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_ram_dma #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int USDW_W    = 8,
    parameter int LEN_W     = 9,
    parameter int SHOWAHEAD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_transfer,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  xfer_len,
    output logic              busy,
    output logic              ready,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_done,
    fifo_ram_dma_if.master    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Showahead has nothing in flight, so it can end straight from RUN.
    localparam state_t c_end_state = (SHOWAHEAD != 0) ? ST_IDLE : ST_FLUSH;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  reads_q, reads_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              aborted_q, aborted_d;
    logic              ready_q, ready_d;
    logic              rdreq_q, rdreq_d;

    logic [USDW_W-1:0] w_usdw_min;
    logic              w_len_ok;
    logic              w_elig;
    logic              w_rdreq;
    logic              w_last;
    logic              w_wren;
    logic [ADDR_W-1:0] w_addr;

    // usedw lags a read by a cycle in normal mode; demand one spare word then.
    assign w_usdw_min = ((SHOWAHEAD == 0) && rdreq_q) ? USDW_W'(1) : '0;
    assign w_len_ok   = (len_q == '0) || (reads_q < len_q);
    assign w_elig     = w_len_ok && (bus.fifo_usdw > w_usdw_min);
    assign w_rdreq    = (state_q == ST_RUN) && !abort && w_elig;
    assign w_last     = w_rdreq && (len_q != '0) && ((reads_q + LEN_W'(1)) == len_q);
    assign w_addr     = base_q + reads_q[ADDR_W-1:0];

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        reads_d   = w_rdreq ? (reads_q + LEN_W'(1)) : reads_q;
        words_d   = w_wren ? (words_q + LEN_W'(1)) : words_q;
        aborted_d = aborted_q;
        rdreq_d   = w_rdreq;

        case (state_q)
            ST_IDLE: begin
                if (start_transfer && !abort) begin
                    state_d   = ST_RUN;
                    base_d    = base_addr;
                    len_d     = xfer_len;
                    reads_d   = '0;
                    words_d   = '0;
                    aborted_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = c_end_state;
                end else if (len_q != '0) begin
                    if (w_last) begin
                        state_d = c_end_state;
                    end
                end else if (SHOWAHEAD != 0) begin
                    if (!w_elig) begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.fifo_usdw == '0) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
                if (abort) begin
                    aborted_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            reads_q   <= '0;
            words_q   <= '0;
            aborted_q <= 1'b0;
            ready_q   <= 1'b0;
            rdreq_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            reads_q   <= reads_d;
            words_q   <= words_d;
            aborted_q <= aborted_d;
            ready_q   <= ready_d;
            rdreq_q   <= rdreq_d;
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign w_wren       = w_rdreq;
            assign bus.ram_addr = w_wren ? w_addr : '0;
            assign bus.ram_d    = w_wren ? bus.fifo_q : '0;
        end else begin : g_normal
            logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

            // The word arrives a cycle after its read, so its address is held.
            always_comb begin
                wr_addr_d = w_rdreq ? w_addr : wr_addr_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_addr_q <= '0;
                end else begin
                    wr_addr_q <= wr_addr_d;
                end
            end

            assign w_wren       = rdreq_q;
            assign bus.ram_addr = w_wren ? wr_addr_q : '0;
            assign bus.ram_d    = w_wren ? bus.fifo_q : '0;
        end
    endgenerate

    assign bus.ram_wren   = w_wren;
    assign bus.fifo_rdreq = w_rdreq;
    assign busy           = (state_q != ST_IDLE);
    assign ready          = ready_q;
    assign aborted        = aborted_q;
    assign words_done     = words_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ram_dma.sv
// ============================================================================
//  Module   : tb_fifo_ram_dma
//  Brief    : Directed bench; index 0 = normal-latency DUT, 1 = showahead DUT.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_ram_dma;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start_v;
    logic [1:0] abort_v;
    logic [7:0] base_addr;
    logic [8:0] xfer_len;
    logic [1:0] busy_v, ready_v, aborted_v;
    logic [8:0] words0, words1;

    always #5 clk = ~clk;

    fifo_ram_dma_if #(.DATA_W(8), .ADDR_W(8), .USDW_W(8)) bus0 ();
    fifo_ram_dma_if #(.DATA_W(8), .ADDR_W(8), .USDW_W(8)) bus1 ();

    fifo_ram_dma #(.DATA_W(8), .ADDR_W(8), .USDW_W(8), .LEN_W(9), .SHOWAHEAD(0)) u_dut0 (
        .clk(clk), .reset(reset), .start_transfer(start_v[0]), .abort(abort_v[0]),
        .base_addr(base_addr), .xfer_len(xfer_len), .busy(busy_v[0]), .ready(ready_v[0]),
        .aborted(aborted_v[0]), .words_done(words0), .bus(bus0)
    );

    fifo_ram_dma #(.DATA_W(8), .ADDR_W(8), .USDW_W(8), .LEN_W(9), .SHOWAHEAD(1)) u_dut1 (
        .clk(clk), .reset(reset), .start_transfer(start_v[1]), .abort(abort_v[1]),
        .base_addr(base_addr), .xfer_len(xfer_len), .busy(busy_v[1]), .ready(ready_v[1]),
        .aborted(aborted_v[1]), .words_done(words1), .bus(bus1)
    );

    // FIFO models: word i of a preload holds pl_v + i
    logic [1:0] pl_go;
    logic [7:0] pl_n [2];
    logic [7:0] pl_v [2];
    logic [7:0] cnt  [2];
    logic [7:0] rdp  [2];
    logic [7:0] v0   [2];
    logic [7:0] qreg [2];
    logic [1:0] rd_v, wren_v;
    logic [7:0] addr_s [2];
    logic [7:0] d_s    [2];
    logic [8:0] words_s [2];

    assign rd_v       = {bus1.fifo_rdreq, bus0.fifo_rdreq};
    assign wren_v     = {bus1.ram_wren, bus0.ram_wren};
    assign addr_s[0]  = bus0.ram_addr;
    assign addr_s[1]  = bus1.ram_addr;
    assign d_s[0]     = bus0.ram_d;
    assign d_s[1]     = bus1.ram_d;
    assign words_s[0] = words0;
    assign words_s[1] = words1;

    assign bus0.fifo_usdw = cnt[0];
    assign bus0.fifo_q    = qreg[0];
    assign bus1.fifo_usdw = cnt[1];
    assign bus1.fifo_q    = v0[1] + rdp[1];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pl_go[k]) begin
                cnt[k] <= pl_n[k];
                rdp[k] <= 8'd0;
                v0[k]  <= pl_v[k];
            end else if (rd_v[k] && cnt[k] != 8'd0) begin
                cnt[k]  <= cnt[k] - 8'd1;
                rdp[k]  <= rdp[k] + 8'd1;
                qreg[k] <= v0[k] + rdp[k];
            end
        end
    end

    // Per-run monitor, sampled on the falling edge
    logic       clr;
    int         cyc;
    int         wr_cnt [2], rd_cnt [2], busy_cnt [2], rdy_cnt [2];
    int         rdy_cyc [2], first_wr [2], rd_empty [2];
    logic [7:0] wa [2][16];
    logic [7:0] wd [2][16];

    always @(negedge clk) begin
        if (clr) begin
            cyc = 0;
            for (int k = 0; k < 2; k++) begin
                wr_cnt[k] = 0; rd_cnt[k] = 0; busy_cnt[k] = 0; rdy_cnt[k] = 0;
                rdy_cyc[k] = -1; first_wr[k] = -1; rd_empty[k] = 0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (rd_v[k]) begin
                rd_cnt[k]++;
                if (cnt[k] == 8'd0) rd_empty[k]++;
            end
            if (wren_v[k]) begin
                if (first_wr[k] < 0) first_wr[k] = cyc;
                if (wr_cnt[k] < 16) begin
                    wa[k][wr_cnt[k]] = addr_s[k];
                    wd[k][wr_cnt[k]] = d_s[k];
                end
                wr_cnt[k]++;
            end
            if (busy_v[k]) busy_cnt[k]++;
            if (ready_v[k]) begin
                rdy_cnt[k]++;
                rdy_cyc[k] = cyc;
            end
        end
        cyc++;
    end

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] n, input logic [7:0] v);
        tick();
        pl_go = 2'b11;
        pl_n[0] = n; pl_n[1] = n;
        pl_v[0] = v; pl_v[1] = v;
        tick();
        pl_go = 2'b00;
    endtask

    task automatic go(input logic [1:0] mask, input logic [7:0] b, input logic [8:0] l, input int ncyc);
        tick();
        base_addr = b;
        xfer_len  = l;
        start_v   = mask;
        clr       = 1'b1;
        tick();
        start_v = 2'b00;
        clr     = 1'b0;
        repeat (ncyc) tick();
    endtask

    task automatic chk_run(input int k, input string tag, input int nwr, input int fwr,
                           input int nbusy, input int rcyc, input logic [7:0] b,
                           input logic [7:0] v, input int words, input int usedw);
        check($sformatf("%s%0d_writes", tag, k), wr_cnt[k], nwr);
        check($sformatf("%s%0d_reads", tag, k), rd_cnt[k], nwr);
        check($sformatf("%s%0d_first_wr", tag, k), first_wr[k], fwr);
        check($sformatf("%s%0d_busy_cycles", tag, k), busy_cnt[k], nbusy);
        check($sformatf("%s%0d_ready_count", tag, k), rdy_cnt[k], 1);
        check($sformatf("%s%0d_ready_cycle", tag, k), rdy_cyc[k], rcyc);
        check($sformatf("%s%0d_empty_reads", tag, k), rd_empty[k], 0);
        check($sformatf("%s%0d_words_done", tag, k), words_s[k], words);
        check($sformatf("%s%0d_usedw", tag, k), cnt[k], usedw);
        for (int i = 0; i < nwr && i < 16; i++) begin
            logic [7:0] ea, ed;
            ea = b + 8'(i);
            ed = v + 8'(i);
            check($sformatf("%s%0d_addr%0d", tag, k, i), wa[k][i], ea);
            check($sformatf("%s%0d_data%0d", tag, k, i), wd[k][i], ed);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s%0d", tag, k),
                  {busy_v[k], ready_v[k], aborted_v[k], words_s[k], rd_v[k], wren_v[k],
                   addr_s[k], d_s[k]}, 32'd0);
        end
    endtask

    task automatic scenario_len4();
        preload(8'd10, 8'h00);
        go(2'b11, 8'h20, 9'd4, 10);
        chk_run(1, "len4_", 4, 1, 4, 5, 8'h20, 8'h00, 4, 6);
        chk_run(0, "len4_", 4, 2, 5, 6, 8'h20, 8'h00, 4, 6);
        check("len4_aborted0", aborted_v[0], 1'b0);
        check("len4_aborted1", aborted_v[1], 1'b0);
    endtask

    initial begin
        reset = 1'b1; start_v = 2'b00; abort_v = 2'b00; base_addr = 8'h00; xfer_len = 9'd0;
        clr = 1'b1; pl_go = 2'b11;
        pl_n[0] = 8'd0; pl_n[1] = 8'd0; pl_v[0] = 8'd0; pl_v[1] = 8'd0;
        repeat (3) tick();
        reset = 1'b0; pl_go = 2'b00; clr = 1'b0;
        @(negedge clk);
        chk_outs_zero("reset_outs");

        scenario_len4();

        // Drain mode with three words; normal mode stalls once on the usedw guard
        preload(8'd3, 8'hA0);
        go(2'b11, 8'h40, 9'd0, 10);
        chk_run(1, "drain3_", 3, 1, 4, 5, 8'h40, 8'hA0, 3, 0);
        chk_run(0, "drain3_", 3, 2, 6, 7, 8'h40, 8'hA0, 3, 0);

        preload(8'd0, 8'h00);
        go(2'b11, 8'h40, 9'd0, 6);
        chk_run(1, "drain0_", 0, -1, 1, 2, 8'h40, 8'h00, 0, 0);
        chk_run(0, "drain0_", 0, -1, 2, 3, 8'h40, 8'h00, 0, 0);

        preload(8'd4, 8'h50);
        go(2'b11, 8'hFE, 9'd4, 10);
        chk_run(1, "wrap_", 4, 1, 4, 5, 8'hFE, 8'h50, 4, 0);
        chk_run(0, "wrap_", 4, 2, 6, 7, 8'hFE, 8'h50, 4, 0);

        // Abort on cycle 4 of a len=8 run; start held high through cycle 3
        preload(8'd10, 8'h60);
        tick();
        base_addr = 8'h30; xfer_len = 9'd8; start_v = 2'b01; clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        tick();
        start_v = 2'b00; abort_v = 2'b01;
        tick();
        abort_v = 2'b00;
        repeat (6) tick();
        chk_run(0, "abort_", 3, 2, 5, 6, 8'h30, 8'h60, 3, 7);
        check("abort_aborted0", aborted_v[0], 1'b1);
        check("abort_idle_dut1_busy", busy_cnt[1], 0);

        tick();
        start_v = 2'b11; abort_v = 2'b11; clr = 1'b1;
        tick();
        start_v = 2'b00; abort_v = 2'b00; clr = 1'b0;
        repeat (4) tick();
        check("abortstart_busy0", busy_cnt[0], 0);
        check("abortstart_busy1", busy_cnt[1], 0);
        check("abortstart_words0", words_s[0], 9'd3);
        check("abortstart_aborted0", aborted_v[0], 1'b1);

        // Reset in the middle of a len=8 transfer
        preload(8'd10, 8'h00);
        tick();
        base_addr = 8'h10; xfer_len = 9'd8; start_v = 2'b11; clr = 1'b1;
        tick();
        start_v = 2'b00; clr = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_outs_zero("midreset_outs");
        repeat (4) tick();
        check("midreset_ready0", rdy_cnt[0], 0);
        check("midreset_ready1", rdy_cnt[1], 0);

        scenario_len4();

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
